// File: rtl/ripple_mon_pkg.sv
// ripple_mon_pkg: shared FSM state type and next-count helper for the ripple counter monitor
// Contents:
//   state_t       - IDLE / ACQUIRE / LOCKED sequence-tracking states
//   next_expected - legal successor of a count within [min, max], wrapping max -> min
package ripple_mon_pkg;

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    // Callers truncate the result to their bus width, so prev+1 wraps modulo 2**WIDTH.
    function automatic logic [31:0] next_expected(
        input logic [31:0] prev,
        input logic [31:0] min,
        input logic [31:0] max
    );
        return (prev == max) ? min : prev + 32'd1;
    endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// ripple_sync_filter: brings the ripple counter bus into clk and filters out ripple transients
// Ports:
//   clk       in   rising-edge clock
//   clear     in   synchronous active-high reset
//   i_count   in   raw asynchronous count bus
//   o_value   out  synchronized value (last synchronizer stage)
//   o_stable  out  high while o_value has held for STABLE_CYCLES samples, counting the next edge
module ripple_sync_filter
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_count,
    output logic [WIDTH-1:0] o_value,
    output logic             o_stable
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [SW-1:0]    r_stab;
    logic [SW-1:0]    w_stab_nxt;

    assign o_value = r_sync[SYNC_STAGES-1];

    // The whole bus restarts the run on any change, so a partially rippled value never matures.
    always_comb begin
        w_stab_nxt = (o_value != r_prev)           ? SW'(1) :
                     (r_stab == SW'(STABLE_CYCLES)) ? r_stab  : r_stab + 1'b1;
    end

    // Looking at the next count lets the consumer register the accept on the maturing edge.
    assign o_stable = (w_stab_nxt == SW'(STABLE_CYCLES));

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
            r_stab <= '0;
        end else begin
            r_sync[0] <= i_count;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= o_value;
            r_stab <= w_stab_nxt;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: turns a ripple counter bus into a clean, checked single-clock count stream
// Ports:
//   clk          in   rising-edge clock
//   clear        in   synchronous active-high reset
//   count_in     in   raw ripple counter bus, asynchronous to clk
//   count_out    out  last accepted settled value
//   count_valid  out  1-cycle pulse when count_out updates
//   wrap         out  pulse with count_valid on legal CNT_MAX -> CNT_MIN
//   seq_error    out  pulse with count_valid on an illegal transition
//   range_error  out  pulse with count_valid on a value outside [CNT_MIN, CNT_MAX]
//   locked       out  level, LOCK_RUN legal transitions since the last error or reset
//   err_count    out  saturating count of sequence errors taken while locked
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_MIN       = 0,
    parameter int CNT_MAX       = 15,
    parameter int LOCK_RUN      = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     count_in,
    output logic [WIDTH-1:0]     count_out,
    output logic                 count_valid,
    output logic                 wrap,
    output logic                 seq_error,
    output logic                 range_error,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int RW = $clog2(LOCK_RUN + 1);

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     w_value, w_exp;
    logic                 w_stable, w_acc, w_in_range, w_legal;
    logic [RW-1:0]        r_run, w_run_nxt;
    logic [WIDTH-1:0]     r_count;
    logic                 r_valid, r_wrap, r_seq, r_range;
    logic [ERR_CNT_W-1:0] r_err, w_err_nxt;
    logic                 w_wrap, w_seq, w_range;

    ripple_sync_filter #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .clear    (clear),
        .i_count  (count_in),
        .o_value  (w_value),
        .o_stable (w_stable)
    );

    // A settled value equal to count_out is a glitch that came back, so it is not re-accepted.
    assign w_acc      = w_stable && (r_state == IDLE || w_value != r_count);
    assign w_in_range = (32'(w_value) >= 32'(CNT_MIN)) && (32'(w_value) <= 32'(CNT_MAX));
    assign w_exp      = WIDTH'(next_expected(32'(r_count), 32'(CNT_MIN), 32'(CNT_MAX)));
    assign w_legal    = w_in_range && (w_value == w_exp);

    always_ff @(posedge clk) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = !w_acc              ? r_state :
                      (r_state == IDLE)   ? ACQUIRE :
                      !w_legal            ? ACQUIRE :
                      (r_state == LOCKED) ? LOCKED  :
                      (r_run + 1'b1 == RW'(LOCK_RUN)) ? LOCKED : ACQUIRE;
    end

    always_comb begin
        w_run_nxt = !w_acc                          ? r_run         :
                    (r_state == ACQUIRE && w_legal) ? r_run + 1'b1  :
                    (r_state == LOCKED  && w_legal) ? r_run         : '0;
        w_wrap    = w_acc && r_state != IDLE && w_legal && 32'(r_count) == 32'(CNT_MAX);
        w_seq     = w_acc && r_state != IDLE && !w_legal;
        w_range   = w_acc && !w_in_range;
        w_err_nxt = (w_acc && r_state == LOCKED && !w_legal && r_err != '1) ? r_err + 1'b1 : r_err;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_run   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_seq   <= 1'b0;
            r_range <= 1'b0;
            r_err   <= '0;
        end else begin
            r_run   <= w_run_nxt;
            r_count <= w_acc ? w_value : r_count;
            r_valid <= w_acc;
            r_wrap  <= w_wrap;
            r_seq   <= w_seq;
            r_range <= w_range;
            r_err   <= w_err_nxt;
        end
    end

    assign count_out   = r_count;
    assign count_valid = r_valid;
    assign wrap        = r_wrap;
    assign seq_error   = r_seq;
    assign range_error = r_range;
    assign locked      = (r_state == LOCKED);
    assign err_count   = r_err;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor: scoreboard bench for ripple_count_monitor (default and CNT_MAX=9 instances)
module tb_ripple_count_monitor;
    import ripple_mon_pkg::*;

    typedef struct packed {
        logic [3:0] v;
        logic       w;
        logic       s;
        logic       r;
        logic       l;
        logic [7:0] e;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear, clear9;
    logic [3:0] count_in, count_in9;
    logic [3:0] count_out, count_out9;
    logic       count_valid, wrap, seq_error, range_error, locked;
    logic       count_valid9, wrap9, seq_error9, range_error9, locked9;
    logic [7:0] err_count, err_count9;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   nv    = 0;
    int   v_cyc = 0;
    int   set_cyc;
    int   e9;
    exp_t q[$];
    exp_t q9[$];
    exp_t m_e, m_e9;

    ripple_count_monitor dut (
        .clk(clk), .clear(clear), .count_in(count_in), .count_out(count_out),
        .count_valid(count_valid), .wrap(wrap), .seq_error(seq_error),
        .range_error(range_error), .locked(locked), .err_count(err_count)
    );

    ripple_count_monitor #(.CNT_MAX(9)) dut9 (
        .clk(clk), .clear(clear9), .count_in(count_in9), .count_out(count_out9),
        .count_valid(count_valid9), .wrap(wrap9), .seq_error(seq_error9),
        .range_error(range_error9), .locked(locked9), .err_count(err_count9)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, x);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] v, input logic w, input logic s,
                                input logic r, input logic l, input logic [7:0] e);
        return '{v, w, s, r, l, e};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] v, input int hold, input exp_t e);
        count_in = v;
        q.push_back(e);
        tick(hold);
    endtask

    task automatic put9(input logic [3:0] v, input int hold, input exp_t e);
        count_in9 = v;
        q9.push_back(e);
        tick(hold);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (q.size() > 0 || q9.size() > 0); i++) tick(1);
        chk("drain", 32'(q.size() + q9.size()), 0);
    endtask

    always @(negedge clk) begin
        if (count_valid) begin
            nv <= nv + 1;
            v_cyc <= cyc;
            if (q.size() == 0) chk("unexpected_valid", {28'd0, count_out}, 32'hFFFF);
            else begin
                m_e = q.pop_front();
                chk("pulse", {count_out, wrap, seq_error, range_error, locked, err_count}, m_e);
            end
        end else chk("quiet", {29'd0, wrap, seq_error, range_error}, 0);
    end

    always @(negedge clk) begin
        if (count_valid9) begin
            if (q9.size() == 0) chk("unexpected_valid9", {28'd0, count_out9}, 32'hFFFF);
            else begin
                m_e9 = q9.pop_front();
                chk("pulse9", {count_out9, wrap9, seq_error9, range_error9, locked9, err_count9}, m_e9);
            end
        end else chk("quiet9", {29'd0, wrap9, seq_error9, range_error9}, 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        clear = 1'b1; clear9 = 1'b1; count_in = 4'b1010; count_in9 = 4'd12;
        tick(2);
        chk("reset_out", {count_valid, count_out, wrap, seq_error, range_error, locked, err_count}, 0);
        chk("reset_state", 32'(dut.r_state), 32'(IDLE));

        count_in = 4'd0;
        clear = 1'b0;
        q.push_back(mk(4'd0, 0, 0, 0, 0, 8'd0));
        tick(8);
        for (int v = 1; v < 16; v++) put(4'(v), 8, mk(4'(v), 0, 0, 0, v >= 4, 8'd0));
        put(4'd0, 8, mk(4'd0, 1, 0, 0, 1, 8'd0));
        drain();
        chk("t2_pulses", 32'(nv), 17);
        chk("t2_locked", {31'd0, locked}, 1);

        for (int v = 1; v < 8; v++) put(4'(v), 8, mk(4'(v), 0, 0, 0, 1, 8'd0));
        count_in = 4'b0110; tick(1);
        count_in = 4'b0100; tick(1);
        count_in = 4'b0000; tick(1);
        set_cyc = cyc;
        put(4'b1000, 8, mk(4'd8, 0, 0, 0, 1, 8'd0));
        drain();
        chk("t3_latency", 32'(v_cyc - set_cyc - 1), 4);
        chk("t3_pulses", 32'(nv), 25);

        count_in = 4'd1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        put(4'd1, 8, mk(4'd1, 0, 0, 0, 0, 8'd0));
        for (int v = 2; v < 6; v++) put(4'(v), 8, mk(4'(v), 0, 0, 0, v == 5, 8'd0));
        put(4'd9, 8, mk(4'd9, 0, 1, 0, 0, 8'd1));
        for (int v = 10; v < 14; v++) put(4'(v), 8, mk(4'(v), 0, 0, 0, v == 13, 8'd1));
        drain();
        chk("t4_err", {24'd0, err_count}, 1);
        chk("t4_locked", {31'd0, locked}, 1);

        count_in = 4'd14;
        tick(4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("t6_noacc", {count_valid, count_out, locked, err_count}, 0);
        chk("t6_state", 32'(dut.r_state), 32'(IDLE));
        put(4'd14, 10, mk(4'd14, 0, 0, 0, 0, 8'd0));
        put(4'd15, 8, mk(4'd15, 0, 0, 0, 0, 8'd0));
        put(4'd0, 8, mk(4'd0, 1, 0, 0, 0, 8'd0));
        drain();

        clear9 = 1'b0;
        put9(4'd12, 8, mk(4'd12, 0, 0, 1, 0, 8'd0));
        put9(4'd0, 8, mk(4'd0, 0, 1, 0, 0, 8'd0));
        for (int v = 1; v < 5; v++) put9(4'(v), 8, mk(4'(v), 0, 0, 0, v == 4, 8'd0));
        put9(4'd12, 8, mk(4'd12, 0, 1, 1, 0, 8'd1));
        put9(4'd0, 8, mk(4'd0, 0, 1, 0, 0, 8'd1));
        for (int v = 1; v < 5; v++) put9(4'(v), 8, mk(4'(v), 0, 0, 0, v == 4, 8'd1));
        drain();
        e9 = 1;
        for (int k = 0; k < 256; k++) begin
            e9 = (e9 == 255) ? 255 : e9 + 1;
            put9(4'd0, 6, mk(4'd0, 0, 1, 0, 0, 8'(e9)));
            for (int v = 1; v < 5; v++) put9(4'(v), 6, mk(4'(v), 0, 0, 0, v == 4, 8'(e9)));
        end
        drain();
        chk("t5_err_sat", {24'd0, err_count9}, 255);
        chk("t5_locked", {31'd0, locked9}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
